// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, flag bit positions and driver states for the ALU front-end
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD     = 3'd0,
    OP_SUB     = 3'd1,
    OP_SHR     = 3'd2,
    OP_SHL     = 3'd3,
    OP_AND     = 3'd4,
    OP_OR      = 3'd5,
    OP_XOR     = 3'd6,
    OP_ILLEGAL = 3'd7
  } alu_op_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef logic [1:0] drv_state_t;
  localparam drv_state_t ST_IDLE = 2'd0;
  localparam drv_state_t ST_EXEC = 2'd1;
  localparam drv_state_t ST_RESP = 2'd2;

endpackage

// File: rtl/alu_driver_settle_cnt.sv
// rtl/alu_driver_settle_cnt.sv - loadable down-counter timing how long ALU inputs settle
module alu_driver_settle_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/alu_driver.sv
// rtl/alu_driver.sv - command/response front-end that registers ALU operands and captures results
module alu_driver
  import alu_pkg::*;
#(
  parameter int N      = 4,
  parameter int SETTLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic [N-1:0] cmd_a,
  input  logic [N-1:0] cmd_b,
  input  logic         cmd_use_acc,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [2:0]   alu_op,
  input  logic [N-1:0] alu_r,
  input  logic         alu_n,
  input  logic         alu_z,
  input  logic         alu_c,
  input  logic         alu_v,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_r,
  output logic [3:0]   rsp_flags,
  output logic         rsp_err,
  output logic [N-1:0] acc,
  output logic [7:0]   op_count
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

  drv_state_t   state_q, state_d;
  logic [N-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [2:0]   alu_op_q, alu_op_d;
  logic [N-1:0] rsp_r_q, rsp_r_d, acc_q, acc_d;
  logic [3:0]   rsp_flags_q, rsp_flags_d;
  logic         rsp_err_q, rsp_err_d;
  logic [7:0]   op_count_q, op_count_d;
  logic         cnt_load, cnt_dec, cnt_zero;

  alu_driver_settle_cnt #(.W(4)) u_settle (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (SETTLE_LOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    rsp_r_d     = rsp_r_q;
    rsp_flags_d = rsp_flags_q;
    rsp_err_d   = rsp_err_q;
    acc_d       = acc_q;
    op_count_d  = op_count_q;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          // Illegal opcodes never reach the ALU; operands and history stay intact.
          if (cmd_op == OP_ILLEGAL) begin
            rsp_err_d   = 1'b1;
            rsp_r_d     = '0;
            rsp_flags_d = '0;
            state_d     = ST_RESP;
          end else begin
            alu_op_d = cmd_op;
            alu_a_d  = cmd_use_acc ? acc_q : cmd_a;
            alu_b_d  = cmd_b;
            cnt_load = 1'b1;
            state_d  = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        if (cnt_zero) begin
          rsp_r_d             = alu_r;
          rsp_flags_d[FLAG_N] = alu_n;
          rsp_flags_d[FLAG_Z] = alu_z;
          rsp_flags_d[FLAG_C] = alu_c;
          rsp_flags_d[FLAG_V] = alu_v;
          rsp_err_d           = 1'b0;
          acc_d               = alu_r;
          op_count_d          = op_count_q + 8'd1;
          state_d             = ST_RESP;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      rsp_r_q     <= '0;
      rsp_flags_q <= '0;
      rsp_err_q   <= 1'b0;
      acc_q       <= '0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      rsp_r_q     <= rsp_r_d;
      rsp_flags_q <= rsp_flags_d;
      rsp_err_q   <= rsp_err_d;
      acc_q       <= acc_d;
      op_count_q  <= op_count_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign rsp_r     = rsp_r_q;
  assign rsp_flags = rsp_flags_q;
  assign rsp_err   = rsp_err_q;
  assign acc       = acc_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_driver.sv
// tb/tb_alu_driver.sv - directed bench: SETTLE=1 and SETTLE=3 drivers, each with its own reference ALU
module tb_alu_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] cmd_op = '0;
  logic [3:0] cmd_a = '0, cmd_b = '0;
  logic       cmd_use_acc = 1'b0;

  logic       cmd_valid1 = 1'b0, rsp_ready1 = 1'b0, cmd_ready1, rsp_valid1, rsp_err1;
  logic [3:0] alu_a1, alu_b1, alu_r1, rsp_r1, rsp_flags1, acc1;
  logic [2:0] alu_op1;
  logic       alu_n1, alu_z1, alu_c1, alu_v1;
  logic [7:0] op_count1;

  logic       cmd_valid3 = 1'b0, rsp_ready3 = 1'b0, cmd_ready3, rsp_valid3, rsp_err3;
  logic [3:0] alu_a3, alu_b3, alu_r3, rsp_r3, rsp_flags3, acc3;
  logic [2:0] alu_op3;
  logic       alu_n3, alu_z3, alu_c3, alu_v3;
  logic [7:0] op_count3;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  // Reference ALU: add sets C and V from carry-out, sub returns |a-b| with N for a<b.
  function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    logic [3:0] r;
    logic n, c, v;
    s = '0; r = '0; n = 1'b0; c = 1'b0; v = 1'b0;
    case (op)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[3:0]; c = s[4]; v = s[4]; end
      3'd1: begin if (a < b) begin r = b - a; n = 1'b1; end else r = a - b; end
      3'd2: begin r = a >> 1; c = a[0]; end
      3'd3: begin r = a << 1; c = a[3]; end
      3'd4: begin r = a & b; n = r[3]; end
      3'd5: begin r = a | b; n = r[3]; end
      3'd6: begin r = a ^ b; n = r[3]; end
      default: r = '0;
    endcase
    return {n, (r == 4'd0), c, v, r};
  endfunction

  assign {alu_n1, alu_z1, alu_c1, alu_v1, alu_r1} = alu_f(alu_op1, alu_a1, alu_b1);
  assign {alu_n3, alu_z3, alu_c3, alu_v3, alu_r3} = alu_f(alu_op3, alu_a3, alu_b3);

  alu_driver #(.N(4), .SETTLE(1)) u1 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc), .alu_a(alu_a1), .alu_b(alu_b1),
    .alu_op(alu_op1), .alu_r(alu_r1), .alu_n(alu_n1), .alu_z(alu_z1), .alu_c(alu_c1), .alu_v(alu_v1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_r(rsp_r1), .rsp_flags(rsp_flags1),
    .rsp_err(rsp_err1), .acc(acc1), .op_count(op_count1)
  );

  alu_driver #(.N(4), .SETTLE(3)) u3 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc), .alu_a(alu_a3), .alu_b(alu_b3),
    .alu_op(alu_op3), .alu_r(alu_r3), .alu_n(alu_n3), .alu_z(alu_z3), .alu_c(alu_c3), .alu_v(alu_v3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_r(rsp_r3), .rsp_flags(rsp_flags3),
    .rsp_err(rsp_err3), .acc(acc3), .op_count(op_count3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one command into u1 and returns edges from accept to rsp_valid (20 = timed out).
  task automatic issue1(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic ua, output int lat);
    @(negedge clk);
    chk("cmd_ready_idle", {31'd0, cmd_ready1}, 32'd1);
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = ua;
    cmd_valid1 = 1'b1;
    rsp_ready1 = 1'b1;
    @(negedge clk);
    cmd_valid1 = 1'b0;
    lat = 0;
    while (!rsp_valid1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  typedef struct {
    logic [2:0] op;
    logic [3:0] a, b;
    logic       ua;
    logic [3:0] r, fl;
    logic       err;
    logic [3:0] acc;
    logic [7:0] cnt;
    logic [3:0] ea, eb;
    logic [2:0] eop;
    int         lat;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int lat;
    vecs[0] = '{3'd0, 4'd3, 4'd5, 1'b0, 4'd8, 4'b0000, 1'b0, 4'd8, 8'd1, 4'd3, 4'd5, 3'd0, 1};
    vecs[1] = '{3'd0, 4'd9, 4'd8, 1'b0, 4'd1, 4'b0011, 1'b0, 4'd1, 8'd2, 4'd9, 4'd8, 3'd0, 1};
    vecs[2] = '{3'd0, 4'hF, 4'd2, 1'b1, 4'd3, 4'b0000, 1'b0, 4'd3, 8'd3, 4'd1, 4'd2, 3'd0, 1};
    vecs[3] = '{3'd1, 4'd3, 4'd5, 1'b0, 4'd2, 4'b1000, 1'b0, 4'd2, 8'd4, 4'd3, 4'd5, 3'd1, 1};
    vecs[4] = '{3'd1, 4'd5, 4'd5, 1'b0, 4'd0, 4'b0100, 1'b0, 4'd0, 8'd5, 4'd5, 4'd5, 3'd1, 1};
    vecs[5] = '{3'd6, 4'hA, 4'h6, 1'b0, 4'hC, 4'b1000, 1'b0, 4'hC, 8'd6, 4'hA, 4'h6, 3'd6, 1};
    vecs[6] = '{3'd7, 4'd4, 4'd4, 1'b0, 4'd0, 4'b0000, 1'b1, 4'hC, 8'd6, 4'hA, 4'h6, 3'd6, 0};
    vecs[7] = '{3'd4, 4'd3, 4'hA, 1'b1, 4'd8, 4'b1000, 1'b0, 4'd8, 8'd7, 4'hC, 4'hA, 3'd4, 1};
    vecs[8] = '{3'd3, 4'd9, 4'd0, 1'b0, 4'd2, 4'b0010, 1'b0, 4'd2, 8'd8, 4'd9, 4'd0, 3'd3, 1};
    vecs[9] = '{3'd2, 4'd1, 4'd0, 1'b0, 4'd0, 4'b0110, 1'b0, 4'd0, 8'd9, 4'd1, 4'd0, 3'd2, 1};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_cmd_ready", {31'd0, cmd_ready1}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid1}, 32'd0);
    chk("rst_acc", {28'd0, acc1}, 32'd0);
    chk("rst_op_count", {24'd0, op_count1}, 32'd0);
    chk("rst_alu", {21'd0, alu_op1, alu_a1, alu_b1}, 32'd0);
    chk("rst_rsp", {23'd0, rsp_err1, rsp_flags1, rsp_r1}, 32'd0);

    foreach (vecs[i]) begin
      issue1(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ua, lat);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_rsp_r", i), {28'd0, rsp_r1}, {28'd0, vecs[i].r});
      chk($sformatf("v%0d_flags", i), {28'd0, rsp_flags1}, {28'd0, vecs[i].fl});
      chk($sformatf("v%0d_err", i), {31'd0, rsp_err1}, {31'd0, vecs[i].err});
      chk($sformatf("v%0d_acc", i), {28'd0, acc1}, {28'd0, vecs[i].acc});
      chk($sformatf("v%0d_op_count", i), {24'd0, op_count1}, {24'd0, vecs[i].cnt});
      chk($sformatf("v%0d_alu_a", i), {28'd0, alu_a1}, {28'd0, vecs[i].ea});
      chk($sformatf("v%0d_alu_b", i), {28'd0, alu_b1}, {28'd0, vecs[i].eb});
      chk($sformatf("v%0d_alu_op", i), {29'd0, alu_op1}, {29'd0, vecs[i].eop});
    end

    // SETTLE=3: operands held through settle, response held while the consumer stalls.
    @(negedge clk);
    cmd_op = 3'd6; cmd_a = 4'hA; cmd_b = 4'h6; cmd_use_acc = 1'b0;
    cmd_valid3 = 1'b1; rsp_ready3 = 1'b0;
    @(negedge clk);
    cmd_valid3 = 1'b0;
    lat = 0;
    while (!rsp_valid3 && lat < 20) begin
      chk("s3_alu_stable", {17'd0, alu_op3, alu_a3, alu_b3, cmd_ready3}, {17'd0, 3'd6, 4'hA, 4'h6, 1'b0});
      @(negedge clk);
      lat++;
    end
    chk("s3_latency", lat, 3);
    cmd_op = 3'd0; cmd_a = 4'd1; cmd_b = 4'd1; cmd_valid3 = 1'b1;
    repeat (5) begin
      chk("s3_rsp_hold", {17'd0, rsp_valid3, rsp_r3, rsp_flags3, cmd_ready3, alu_op3},
          {17'd0, 1'b1, 4'hC, 4'b1000, 1'b0, 3'd6});
      @(negedge clk);
    end
    rsp_ready3 = 1'b1;
    @(negedge clk);
    chk("s3_bubble", {20'd0, rsp_valid3, cmd_ready3, alu_op3, op_count3},
        {20'd0, 1'b0, 1'b1, 3'd6, 8'd1});
    cmd_valid3 = 1'b0; rsp_ready3 = 1'b0;

    // Reset while u3 is mid-EXEC.
    @(negedge clk);
    cmd_valid3 = 1'b1;
    @(negedge clk);
    cmd_valid3 = 1'b0;
    chk("s3_in_exec", {30'd0, rsp_valid3, cmd_ready3}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_exec", {14'd0, rsp_valid3, cmd_ready3, acc3, op_count3, alu_a3}, {14'd0, 1'b0, 1'b1, 16'd0});
    repeat (3) @(negedge clk);
    chk("rst_exec_discard", {31'd0, rsp_valid3}, 32'd0);

    // Reset while u1 is holding a response.
    @(negedge clk);
    cmd_op = 3'd0; cmd_a = 4'd2; cmd_b = 4'd3; cmd_valid1 = 1'b1; rsp_ready1 = 1'b0;
    @(negedge clk);
    cmd_valid1 = 1'b0;
    lat = 0;
    while (!rsp_valid1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("resp_before_rst", {27'd0, rsp_valid1, rsp_r1}, {27'd0, 1'b1, 4'd5});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_resp", {14'd0, rsp_valid1, cmd_ready1, acc1, op_count1, rsp_r1}, {14'd0, 1'b0, 1'b1, 16'd0});

    for (int i = 0; i < 256; i++) begin
      issue1(3'd0, 4'd1, 4'd1, 1'b0, lat);
      if (i == 254) chk("op_count_255", {24'd0, op_count1}, 32'd255);
    end
    chk("op_count_wrap", {24'd0, op_count1}, 32'd0);
    chk("wrap_acc", {28'd0, acc1}, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
